// File: rtl/mac_pkg.sv
// Shared types and sizing for the MAC memory sequencer.
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        STORE,
        DONE
    } mac_mem_state_e;

    localparam int unsigned MAC_ROWS       = 3;
    localparam int unsigned MAC_LOAD_WORDS = 6;

endpackage

// File: rtl/mac_mem_ctrl.sv
// Memory sequencer for mac_wrapper: loads A/B rows, hands them to the MAC,
// then stores the three result rows. Stalls the pipeline while active.
module mac_mem_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ROW_STRIDE = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [1:0]        opcode_i,
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic [ADDR_W-1:0] rs2_i,
    input  logic [ADDR_W-1:0] rd_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        mac_opcode_o,
    output logic [DATA_W-1:0] mac_data1_o,
    output logic [DATA_W-1:0] mac_data2_o,
    output logic [DATA_W-1:0] mac_data3_o,
    output logic [DATA_W-1:0] mac_data4_o,
    output logic [DATA_W-1:0] mac_data5_o,
    output logic [DATA_W-1:0] mac_data6_o,
    input  logic [DATA_W-1:0] mac_res1_i,
    input  logic [DATA_W-1:0] mac_res2_i,
    input  logic [DATA_W-1:0] mac_res3_i
);

    mac_mem_state_e    state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [1:0]        opcode_q, opcode_d;
    logic [ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [DATA_W-1:0] ops_q [MAC_LOAD_WORDS];
    logic [DATA_W-1:0] ops_d [MAC_LOAD_WORDS];
    logic [DATA_W-1:0] res_q [MAC_ROWS];
    logic [DATA_W-1:0] res_d [MAC_ROWS];
    logic              err_q, err_d;

    logic [2:0]        row_sel;
    logic [ADDR_W-1:0] row_off;
    logic              misaligned;

    // Reads 3..5 walk matrix B, so the row number restarts at 0 there.
    always_comb begin
        row_sel    = (idx_q >= 3'(MAC_ROWS)) ? idx_q - 3'(MAC_ROWS) : idx_q;
        row_off    = ADDR_W'(row_sel) * ADDR_W'(ROW_STRIDE);
        misaligned = (rs1_i[1:0] | rs2_i[1:0] | rd_i[1:0]) != 2'b00;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        opcode_d    = opcode_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        ops_d       = ops_q;
        res_d       = res_q;
        err_d       = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        busy_o      = (state_q != IDLE);
        done_o      = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        opcode_d = opcode_i;
                        rs1_d    = rs1_i;
                        rs2_d    = rs2_i;
                        rd_d     = rd_i;
                        idx_d    = '0;
                        state_d  = LOAD;
                    end
                end
            end
            LOAD: begin
                mem_req_o  = 1'b1;
                mem_addr_o = ((idx_q < 3'(MAC_ROWS)) ? rs1_q : rs2_q) + row_off;
                if (mem_ready_i) begin
                    if (idx_q < 3'(MAC_LOAD_WORDS)) begin
                        ops_d[idx_q] = mem_rdata_i;
                    end
                    if (idx_q == 3'(MAC_LOAD_WORDS - 1)) begin
                        idx_d   = '0;
                        state_d = COMPUTE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            COMPUTE: begin
                res_d[0] = mac_res1_i;
                res_d[1] = mac_res2_i;
                res_d[2] = mac_res3_i;
                idx_d    = '0;
                state_d  = STORE;
            end
            STORE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = rd_q + row_off;
                mem_wdata_o = res_q[idx_q[1:0]];
                if (mem_ready_i) begin
                    if (idx_q == 3'(MAC_ROWS - 1)) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            opcode_q <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            ops_q    <= '{default: '0};
            res_q    <= '{default: '0};
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            opcode_q <= opcode_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            ops_q    <= ops_d;
            res_q    <= res_d;
            err_q    <= err_d;
        end
    end

    assign err_o        = err_q;
    assign mac_opcode_o = opcode_q;
    assign mac_data1_o  = ops_q[0];
    assign mac_data2_o  = ops_q[1];
    assign mac_data3_o  = ops_q[2];
    assign mac_data4_o  = ops_q[3];
    assign mac_data5_o  = ops_q[4];
    assign mac_data6_o  = ops_q[5];

endmodule

// File: tb/tb_mac_mem_ctrl.sv
// Bench for mac_mem_ctrl: a memory model answers the DUT's requests and every
// transfer is compared against the transfer list expected for the instruction.
module tb_mac_mem_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [1:0]  opcode_i;
    logic [31:0] rs1_i, rs2_i, rd_i;
    logic        busy_o, done_o, err_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  mac_opcode_o;
    logic [31:0] mac_data1_o, mac_data2_o, mac_data3_o;
    logic [31:0] mac_data4_o, mac_data5_o, mac_data6_o;
    logic [31:0] mac_res1_i, mac_res2_i, mac_res3_i;

    always #5 clk_i = ~clk_i;

    mac_mem_ctrl #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .ROW_STRIDE(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .opcode_i    (opcode_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .rd_i        (rd_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i),
        .mac_opcode_o(mac_opcode_o),
        .mac_data1_o (mac_data1_o),
        .mac_data2_o (mac_data2_o),
        .mac_data3_o (mac_data3_o),
        .mac_data4_o (mac_data4_o),
        .mac_data5_o (mac_data5_o),
        .mac_data6_o (mac_data6_o),
        .mac_res1_i  (mac_res1_i),
        .mac_res2_i  (mac_res2_i),
        .mac_res3_i  (mac_res3_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        if (!mem.exists(addr)) mem[addr] = $urandom;
        return mem[addr];
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_req"}, mem_req_o, 0);
        chk({tag, "_we"}, mem_we_o, 0);
        chk({tag, "_addr"}, mem_addr_o, 0);
        chk({tag, "_wdata"}, mem_wdata_o, 0);
        chk({tag, "_opcode"}, mac_opcode_o, 0);
        chk({tag, "_d1"}, mac_data1_o, 0);
        chk({tag, "_d2"}, mac_data2_o, 0);
        chk({tag, "_d3"}, mac_data3_o, 0);
        chk({tag, "_d4"}, mac_data4_o, 0);
        chk({tag, "_d5"}, mac_data5_o, 0);
        chk({tag, "_d6"}, mac_data6_o, 0);
    endtask

    // mode: 0 ready=1, 1 random ready, 2 two-cycle stall on 3rd read,
    //       3 start pulsed during STORE, 4 reset asserted at read index 4
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input int mode, output int dcyc);
        logic [31:0] exp_data [6];
        logic [31:0] res [3];
        logic [1:0]  op;
        int          nrd;
        int          nxf;
        int          stall;
        bit          pulsed;
        bit          rdy;
        xfer_t       x;
        nrd = 0; nxf = 0; stall = 0; pulsed = 0;
        op = 2'($urandom);
        for (int i = 0; i < 3; i++) res[i] = $urandom;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin x.addr = a + 32'(4 * i); x.we = 0; x.wdata = 0; exp_q.push_back(x); end
        for (int i = 0; i < 3; i++) begin x.addr = b + 32'(4 * i); x.we = 0; x.wdata = 0; exp_q.push_back(x); end
        for (int i = 0; i < 3; i++) begin x.addr = c + 32'(4 * i); x.we = 1; x.wdata = res[i]; exp_q.push_back(x); end

        @(negedge clk_i);
        start_i = 1; opcode_i = op; rs1_i = a; rs2_i = b; rd_i = c;
        mac_res1_i = res[0]; mac_res2_i = res[1]; mac_res3_i = res[2];
        @(posedge clk_i);
        dcyc = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk_i);
            start_i = 0;
            if (done_o) begin
                dcyc = n;
                chk("xfer_count", 64'(nxf), 9);
                chk("exp_left", 64'(exp_q.size()), 0);
                break;
            end
            chk("busy_active", busy_o, 1);
            rdy = 1;
            if (mem_req_o) begin
                if (exp_q.size() == 0) begin
                    chk("extra_req", mem_req_o, 0);
                end else begin
                    chk("addr", mem_addr_o, exp_q[0].addr);
                    chk("we", mem_we_o, exp_q[0].we);
                    chk("wdata", mem_wdata_o, exp_q[0].wdata);
                end
                if (mode == 4 && !mem_we_o && nrd == 4) begin
                    rst_ni = 0;
                    #1;
                    chk_all_zero("abort");
                    dcyc = 0;
                    return;
                end
                if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
                if (mode == 2 && !mem_we_o && mem_addr_o == a + 32'd8 && stall < 2) begin
                    rdy = 0;
                    stall++;
                end
                mem_rdata_i = mem_we_o ? 32'($urandom) : mem_rd(mem_addr_o);
                if (rdy) begin
                    nxf++;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
                    else if (nrd < 6) begin exp_data[nrd] = mem_rdata_i; nrd++; end
                end
                if (mode == 3 && mem_we_o && !pulsed) begin
                    start_i = 1;
                    pulsed  = 1;
                end
            end else begin
                mem_rdata_i = $urandom;
            end
            mem_ready_i = rdy;
        end
        if (dcyc < 0) begin
            chk("timeout", 0, 1);
            return;
        end
        chk("res_d1", mac_data1_o, exp_data[0]);
        chk("res_d2", mac_data2_o, exp_data[1]);
        chk("res_d3", mac_data3_o, exp_data[2]);
        chk("res_d4", mac_data4_o, exp_data[3]);
        chk("res_d5", mac_data5_o, exp_data[4]);
        chk("res_d6", mac_data6_o, exp_data[5]);
        chk("opcode", mac_opcode_o, op);
        @(negedge clk_i);
        chk("idle_busy", busy_o, 0);
        chk("idle_done", done_o, 0);
        chk("idle_req", mem_req_o, 0);
        chk("idle_data_hold", mac_data6_o, exp_data[5]);
    endtask

    int          dc;
    logic [31:0] ra, rb, rc;

    initial begin
        rst_ni = 0; start_i = 0; opcode_i = 0; rs1_i = 0; rs2_i = 0; rd_i = 0;
        mem_ready_i = 1; mem_rdata_i = 0;
        mac_res1_i = 0; mac_res2_i = 0; mac_res3_i = 0;
        repeat (2) @(negedge clk_i);
        chk_all_zero("reset");
        rst_ni = 1;
        @(negedge clk_i);

        run_op(32'h100, 32'h200, 32'h300, 0, dc);
        chk("latency_basic", 64'(dc), 11);

        run_op(32'h100, 32'h200, 32'h300, 2, dc);
        chk("latency_stall", 64'(dc), 13);

        // misaligned rs2: error pulse, no memory traffic
        @(negedge clk_i);
        start_i = 1; rs1_i = 32'h100; rs2_i = 32'h202; rd_i = 32'h300;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 0;
        chk("err_pulse", err_o, 1);
        chk("err_busy", busy_o, 0);
        chk("err_req", mem_req_o, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("err_after", err_o, 0);
            chk("err_after_busy", busy_o, 0);
            chk("err_after_req", mem_req_o, 0);
        end

        run_op(32'h400, 32'h500, 32'h600, 3, dc);
        chk("latency_start_in_store", 64'(dc), 11);
        chk("no_restart_busy", busy_o, 0);

        run_op(32'h700, 32'h800, 32'h900, 4, dc);
        @(negedge clk_i);
        chk("abort_hold_req", mem_req_o, 0);
        chk("abort_hold_busy", busy_o, 0);
        rst_ni = 1;
        @(negedge clk_i);
        run_op(32'h1000, 32'h2000, 32'h1004, 0, dc);
        chk("latency_after_abort", 64'(dc), 11);

        run_op(32'hFFFF_FFFC, 32'h200, 32'h300, 0, dc);
        chk("latency_wrap", 64'(dc), 11);

        for (int k = 0; k < 5; k++) begin
            ra = $urandom & 32'hFFFF_FFFC;
            rb = $urandom & 32'hFFFF_FFFC;
            rc = $urandom & 32'hFFFF_FFFC;
            run_op(ra, rb, rc, 1, dc);
            chk("latency_random_min", 64'(dc >= 11), 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
